// File: rtl/pf_ccc_dri_sequencer.sv
// -----------------------------------------------------------------------------
// pf_ccc_dri_sequencer
//
// Initiator for the PolarFire CCC/PLL dynamic reconfiguration interface (DRI).
// Accepts one register read or write command at a time and drives the PLL DRI
// pins. Read data is captured from DRI_RDATA. A write can optionally wait for
// the PLL to report a stable lock before it responds. CLK is also the DRI clock.
//
// Ports
//   CLK, RESETN         fabric/DRI clock and synchronous active-low reset
//   CMD_VALID/READY     command handshake (accepted when both are high)
//   CMD_WRITE           1 = register write, 0 = register read
//   CMD_WAIT_LOCK       writes only: hold the response until PLL lock settles
//   CMD_ADDR/WDATA      DRI register address and write data
//   RSP_VALID           one-cycle response pulse (no backpressure)
//   RSP_RDATA/ERR       read data (0 for writes) and lock-timeout flag, held
//   DRI_CTRL            {addr[8:0], write, req} to the PLL
//   DRI_WDATA           write data to the PLL, held until the next write
//   DRI_ARST_N          PLL DRI reset, RESETN delayed by one register
//   DRI_RDATA           read data from the PLL
//   PLL_LOCK / LOCKED   raw asynchronous lock in / 2-flop synchronised lock out
// -----------------------------------------------------------------------------
module pf_ccc_dri_sequencer #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic        CMD_WAIT_LOCK,
  input  logic [8:0]  CMD_ADDR,
  input  logic [32:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [32:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [10:0] DRI_CTRL,
  output logic [32:0] DRI_WDATA,
  output logic        DRI_ARST_N,
  input  logic [32:0] DRI_RDATA,
  input  logic        PLL_LOCK,
  output logic        LOCKED
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  // WAIT_RD lasts RD_LAT-1 cycles; its counter runs 0..RD_LAT-2. With RD_LAT=1
  // the data is already valid on the edge that ends ISSUE.
  localparam logic [3:0]  RD_LAST     = (RD_LAT >= 32'd2) ? 4'(RD_LAT - 32'd2) : 4'd0;
  localparam logic        RD_DIRECT   = (RD_LAT <= 32'd1);
  localparam logic [7:0]  STABLE_TGT  = 8'(LOCK_STABLE);
  localparam logic [15:0] TIMEOUT_TGT = 16'(LOCK_TIMEOUT);

  // Saturating increments: lock counters never wrap.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  state_e      state_q,     state_d;
  logic        write_q,     write_d;
  logic        wait_lock_q, wait_lock_d;
  logic [3:0]  rd_cnt_q,    rd_cnt_d;
  logic [7:0]  stable_q,    stable_d;
  logic [15:0] timeout_q,   timeout_d;
  logic        ready_q,     ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [32:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [10:0] dri_ctrl_q,  dri_ctrl_d;
  logic [32:0] dri_wdata_q, dri_wdata_d;
  logic        lock_meta_q;
  logic        lock_sync_q;
  logic        arst_n_q;

  // Next-state and registered-output computation for the command sequencer.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    wait_lock_d = wait_lock_q;
    rd_cnt_d    = rd_cnt_q;
    stable_d    = stable_q;
    timeout_d   = timeout_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    dri_ctrl_d  = 11'd0;
    dri_wdata_d = dri_wdata_q;

    case (state_q)
      S_IDLE: begin
        // ready_q is what the requester sees, so it qualifies the handshake.
        if (CMD_VALID && ready_q) begin
          write_d     = CMD_WRITE;
          wait_lock_d = CMD_WAIT_LOCK;
          rd_cnt_d    = 4'd0;
          stable_d    = 8'd0;
          timeout_d   = 16'd0;
          // The strobe is registered here so it is on the pins during ISSUE.
          dri_ctrl_d  = {CMD_ADDR, CMD_WRITE, 1'b1};
          if (CMD_WRITE) begin
            dri_wdata_d = CMD_WDATA;
          end else begin
            dri_wdata_d = dri_wdata_q;
          end
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (write_q) begin
          if (wait_lock_q) begin
            state_d = S_WAIT_LOCK;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 33'd0;
            rsp_err_d   = 1'b0;
          end
        end else if (RD_DIRECT) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = DRI_RDATA;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = DRI_RDATA;
          rsp_err_d   = 1'b0;
        end else begin
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end

      S_WAIT_LOCK: begin
        // Any low cycle of the synchronised lock restarts the stability run.
        if (lock_sync_q) begin
          stable_d = sat_inc8(stable_q);
        end else begin
          stable_d = 8'd0;
        end
        timeout_d = sat_inc16(timeout_q);
        // Success is tested first so it wins a same-cycle tie with timeout.
        if (stable_d == STABLE_TGT) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 33'd0;
          rsp_err_d   = 1'b0;
        end else if (timeout_d == TIMEOUT_TGT) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 33'd0;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = S_WAIT_LOCK;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State, command latches, counters, outputs and lock synchroniser.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      wait_lock_q <= 1'b0;
      rd_cnt_q    <= 4'd0;
      stable_q    <= 8'd0;
      timeout_q   <= 16'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 33'd0;
      rsp_err_q   <= 1'b0;
      dri_ctrl_q  <= 11'd0;
      dri_wdata_q <= 33'd0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      wait_lock_q <= wait_lock_d;
      rd_cnt_q    <= rd_cnt_d;
      stable_q    <= stable_d;
      timeout_q   <= timeout_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      dri_ctrl_q  <= dri_ctrl_d;
      dri_wdata_q <= dri_wdata_d;
      lock_meta_q <= PLL_LOCK;
      lock_sync_q <= lock_meta_q;
    end
  end

  // PLL DRI reset follows RESETN one cycle later, so it is low throughout reset.
  always_ff @(posedge CLK) begin
    arst_n_q <= RESETN;
  end

  assign CMD_READY  = ready_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RDATA  = rsp_rdata_q;
  assign RSP_ERR    = rsp_err_q;
  assign DRI_CTRL   = dri_ctrl_q;
  assign DRI_WDATA  = dri_wdata_q;
  assign DRI_ARST_N = arst_n_q;
  assign LOCKED     = lock_sync_q;

endmodule

// File: tb/tb_pf_ccc_dri_sequencer.sv
// Testbench for pf_ccc_dri_sequencer: scenario tasks plus a response scoreboard.
module tb_pf_ccc_dri_sequencer;

  localparam int RDL = 2;
  localparam int LS  = 16;
  localparam int LT  = 100;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic        CMD_WAIT_LOCK;
  logic [8:0]  CMD_ADDR;
  logic [32:0] CMD_WDATA;
  logic        RSP_VALID;
  logic [32:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [10:0] DRI_CTRL;
  logic [32:0] DRI_WDATA;
  logic        DRI_ARST_N;
  logic [32:0] DRI_RDATA;
  logic        PLL_LOCK;
  logic        LOCKED;

  pf_ccc_dri_sequencer #(.RD_LAT(RDL), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)) dut (
    .CLK(CLK), .RESETN(RESETN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE), .CMD_WAIT_LOCK(CMD_WAIT_LOCK), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .DRI_CTRL(DRI_CTRL), .DRI_WDATA(DRI_WDATA),
    .DRI_ARST_N(DRI_ARST_N), .DRI_RDATA(DRI_RDATA), .PLL_LOCK(PLL_LOCK),
    .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [32:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_strobe = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every response must match the oldest expectation, including its cycle.
  always @(negedge CLK) begin
    if (DRI_CTRL[0] === 1'b1) n_strobe++;
    if (RSP_VALID === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: RSP_VALID at cycle %0d rdata=%h, required no response", cyc, RSP_RDATA);
      end else begin
        mon_e = exp_q.pop_front();
        if (RSP_RDATA !== mon_e.rdata || RSP_ERR !== mon_e.err || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL rsp_match: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   RSP_RDATA, RSP_ERR, cyc, mon_e.rdata, mon_e.err, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a command at a negedge, wait for acceptance, check the ISSUE strobe.
  task automatic issue_cmd(input logic wr, input logic wl, input logic [8:0] addr,
                           input logic [32:0] wd, input logic push, input logic [32:0] exp_rd,
                           input logic exp_err, input int lat, input logic drop_valid,
                           output int acc);
    int n;
    logic [10:0] exp_ctrl;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_WAIT_LOCK = wl; CMD_ADDR = addr; CMD_WDATA = wd;
    n = 0;
    while (CMD_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL accept_timeout: CMD_READY=%b after %0d cycles, required 1", CMD_READY, n);
    end
    acc = cyc;
    if (push) exp_q.push_back('{exp_rd, exp_err, acc + lat});
    @(negedge CLK);
    if (drop_valid) begin
      CMD_VALID = 1'b0; CMD_WRITE = ~wr; CMD_WAIT_LOCK = ~wl; CMD_ADDR = ~addr; CMD_WDATA = ~wd;
    end
    exp_ctrl = {addr, wr, 1'b1};
    n_checks++;
    if (DRI_CTRL !== exp_ctrl || CMD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_strobe: DRI_CTRL=%h READY=%b, required DRI_CTRL=%h READY=0", DRI_CTRL, CMD_READY, exp_ctrl);
    end
    if (wr) begin
      n_checks++;
      if (DRI_WDATA !== wd) begin
        n_fail++;
        $display("FAIL issue_wdata: DRI_WDATA=%h, required %h", DRI_WDATA, wd);
      end
    end
    @(negedge CLK);
    n_checks++;
    if (DRI_CTRL !== 11'd0) begin
      n_fail++;
      $display("FAIL strobe_clear: DRI_CTRL=%h, required 000", DRI_CTRL);
    end
  endtask

  // Wait (bounded) until all expected responses are consumed.
  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset();
    PLL_LOCK = 1'b1;
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({RSP_VALID, RSP_ERR, CMD_READY, LOCKED, DRI_ARST_N} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid/err/ready/locked/arst=%b, required 00000",
               {RSP_VALID, RSP_ERR, CMD_READY, LOCKED, DRI_ARST_N});
    end
    n_checks++;
    if (RSP_RDATA !== 33'd0 || DRI_CTRL !== 11'd0 || DRI_WDATA !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h ctrl=%h wdata=%h, required all 0", RSP_RDATA, DRI_CTRL, DRI_WDATA);
    end
    RESETN = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (CMD_READY !== 1'b1 || DRI_ARST_N !== 1'b1 || LOCKED !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b arst=%b locked=%b, required 1 1 0", CMD_READY, DRI_ARST_N, LOCKED);
    end
    @(negedge CLK);
    n_checks++;
    if (LOCKED !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_sync: LOCKED=%b, required 1", LOCKED);
    end
  endtask

  task automatic test_read();
    int acc;
    DRI_RDATA = 33'h1_2345_6789;
    issue_cmd(1'b0, 1'b0, 9'h005, 33'h0, 1'b1, 33'h1_2345_6789, 1'b0, RDL + 1, 1'b1, acc);
    drain(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_missing: %0d responses outstanding, required 0", exp_q.size());
    end
    @(negedge CLK);
    n_checks++;
    if (RSP_VALID !== 1'b0 || RSP_RDATA !== 33'h1_2345_6789) begin
      n_fail++;
      $display("FAIL read_hold: valid=%b rdata=%h, required 0 123456789", RSP_VALID, RSP_RDATA);
    end
    // WAIT_LOCK on a read is ignored even with the PLL unlocked.
    PLL_LOCK = 1'b0;
    DRI_RDATA = 33'h0_DEAD_BEEF;
    repeat (2) @(negedge CLK);
    issue_cmd(1'b0, 1'b1, 9'h1F0, 33'h0, 1'b1, 33'h0_DEAD_BEEF, 1'b0, RDL + 1, 1'b1, acc);
    drain(20);
  endtask

  task automatic test_write();
    int acc;
    issue_cmd(1'b1, 1'b0, 9'h01A, 33'h0_0000_007F, 1'b1, 33'd0, 1'b0, 2, 1'b1, acc);
    drain(20);
    n_checks++;
    if (DRI_WDATA !== 33'h0_0000_007F) begin
      n_fail++;
      $display("FAIL wdata_hold: DRI_WDATA=%h, required 00000007f", DRI_WDATA);
    end
  endtask

  task automatic test_lock_wait();
    int acc;
    int h;
    PLL_LOCK = 1'b0;
    repeat (2) @(negedge CLK);
    issue_cmd(1'b1, 1'b1, 9'h0A5, 33'h1_AAAA_5555, 1'b0, 33'd0, 1'b0, 0, 1'b1, acc);
    repeat (8) @(negedge CLK);
    PLL_LOCK = 1'b1;
    h = cyc;
    exp_q.push_back('{33'd0, 1'b0, h + 2 + LS});
    drain(60);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lock_missing: %0d responses outstanding, required 0", exp_q.size());
    end
    // A one-cycle glitch after 10 locked cycles must restart the stability run.
    PLL_LOCK = 1'b0;
    repeat (2) @(negedge CLK);
    issue_cmd(1'b1, 1'b1, 9'h0A6, 33'h0_1234_0000, 1'b0, 33'd0, 1'b0, 0, 1'b1, acc);
    repeat (3) @(negedge CLK);
    PLL_LOCK = 1'b1;
    repeat (10) @(negedge CLK);
    PLL_LOCK = 1'b0;
    @(negedge CLK);
    PLL_LOCK = 1'b1;
    h = cyc;
    exp_q.push_back('{33'd0, 1'b0, h + 2 + LS});
    drain(60);
  endtask

  task automatic test_lock_timeout();
    int acc;
    PLL_LOCK = 1'b0;
    repeat (2) @(negedge CLK);
    issue_cmd(1'b1, 1'b1, 9'h0C3, 33'h1_0000_0001, 1'b1, 33'd0, 1'b1, 2 + LT, 1'b1, acc);
    repeat (28) @(negedge CLK);
    PLL_LOCK = 1'b1;
    repeat (10) @(negedge CLK);
    PLL_LOCK = 1'b0;
    drain(LT + 40);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_missing: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int a1;
    int a2;
    int s0;
    s0 = n_strobe;
    DRI_RDATA = 33'h0_0BAD_CAFE;
    issue_cmd(1'b1, 1'b0, 9'h101, 33'h1_1111_1111, 1'b1, 33'd0, 1'b0, 2, 1'b0, a0);
    issue_cmd(1'b0, 1'b0, 9'h102, 33'h0, 1'b1, 33'h0_0BAD_CAFE, 1'b0, RDL + 1, 1'b0, a1);
    issue_cmd(1'b1, 1'b0, 9'h103, 33'h0_3333_3333, 1'b1, 33'd0, 1'b0, 2, 1'b1, a2);
    drain(20);
    n_checks++;
    if (a1 - a0 != 3 || a2 - a1 != RDL + 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: gaps %0d %0d, required 3 %0d", a1 - a0, a2 - a1, RDL + 2);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (n_strobe - s0 != 3) begin
      n_fail++;
      $display("FAIL b2b_strobes: %0d strobes, required 3", n_strobe - s0);
    end
  endtask

  task automatic test_reset_mid_read();
    int acc;
    PLL_LOCK = 1'b1;
    DRI_RDATA = 33'h1_5555_AAAA;
    repeat (3) @(negedge CLK);
    issue_cmd(1'b0, 1'b0, 9'h044, 33'h0, 1'b0, 33'd0, 1'b0, 0, 1'b1, acc);
    RESETN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({RSP_VALID, RSP_ERR, CMD_READY, LOCKED, DRI_ARST_N} !== 5'b0 ||
        RSP_RDATA !== 33'd0 || DRI_CTRL !== 11'd0 || DRI_WDATA !== 33'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags=%b rdata=%h ctrl=%h wdata=%h, required all 0",
               {RSP_VALID, RSP_ERR, CMD_READY, LOCKED, DRI_ARST_N}, RSP_RDATA, DRI_CTRL, DRI_WDATA);
    end
    RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    issue_cmd(1'b1, 1'b0, 9'h045, 33'h0_0000_0ABC, 1'b1, 33'd0, 1'b0, 2, 1'b1, acc);
    drain(20);
  endtask

  initial begin
    RESETN = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_WAIT_LOCK = 1'b0;
    CMD_ADDR = 9'd0; CMD_WDATA = 33'd0; DRI_RDATA = 33'd0; PLL_LOCK = 1'b0;
    @(negedge CLK);
    test_reset();
    test_read();
    test_write();
    test_lock_wait();
    test_lock_timeout();
    test_back_to_back();
    test_reset_mid_read();
    repeat (5) @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
